// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide sequencer:
// widths, op encodings, FSM states and corner-case classification.
package muldiv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ITER_CNT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CC_NONE = 2'd0,
        CC_DIV0 = 2'd1,
        CC_OVF  = 2'd2,
        CC_ZERO = 2'd3
    } corner_e;

    function automatic logic is_div(op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic a_signed(op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic corner_e corner_of(op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        corner_e cc;
        cc = CC_NONE;
        if (is_div(op)) begin
            if (b == '0)
                cc = CC_DIV0;
            else if (b_signed(op) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1)
                cc = CC_OVF;
        end else if (a == '0 || b == '0) begin
            cc = CC_ZERO;
        end
        return cc;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 datapath: shift-add multiply and restoring divide on magnitudes,
// sharing one 64-bit {hi, lo} register pair (product, or remainder/quotient).
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, b_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_mode) begin
            // Remainder stays below the divisor, so a non-negative diff never reaches bit XLEN.
            if (diff[XLEN+1:XLEN] == 2'b00) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= mag_a;
            b_q  <= mag_b;
        end else if (step) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage multi-cycle MUL/DIV sequencer: FSM, iteration counter, sign and
// corner-case handling. Define MULDIV_EARLY_OUT_EN to skip iterations on trivial operands.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [5:0] CNT_LAST = 6'(ITER_CNT - 1);

    state_e          state_q, state_d;
    logic [5:0]      cnt_q;
    op_e             op_q;
    op_e             op_in;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] core_hi, core_lo;
    logic            accept, early;

    assign op_in  = op_e'(op);
    assign accept = (state_q == IDLE) && start && !flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = corner_of(op_in, src_a, src_b) != CC_NONE;
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = early ? DONE : BUSY;
            BUSY:    if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                op_q  <= op_in;
                a_q   <= src_a;
                b_q   <= src_b;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    assign mag_a = (a_signed(op_in) && src_a[XLEN-1]) ? -src_a : src_a;
    assign mag_b = (b_signed(op_in) && src_b[XLEN-1]) ? -src_b : src_b;

    muldiv_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     ((state_q == BUSY) && !flush),
        .div_mode (is_div(op_q)),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .hi       (core_hi),
        .lo       (core_lo)
    );

    // Result is derived from registers that only change on an accepted start,
    // so it holds steady from DONE until the next operation is taken.
    always_comb begin
        logic            neg_a, neg_b;
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0] quo, rem;
        neg_a = a_signed(op_q) && a_q[XLEN-1];
        neg_b = b_signed(op_q) && b_q[XLEN-1];
        prod  = (neg_a ^ neg_b) ? -{core_hi, core_lo} : {core_hi, core_lo};
        quo   = (neg_a ^ neg_b) ? -core_lo : core_lo;
        rem   = neg_a ? -core_hi : core_hi;
        result = '0;
        case (corner_of(op_q, a_q, b_q))
            CC_DIV0: result = is_rem(op_q) ? a_q : '1;
            CC_OVF:  result = is_rem(op_q) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            CC_ZERO: result = '0;
            default: begin
                if (is_div(op_q))
                    result = is_rem(op_q) ? rem : quo;
                else
                    result = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end
        endcase
    end

    assign busy  = (state_q == BUSY);
    assign done  = (state_q == DONE);
    assign stall = accept || busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors push expected
// result/done-cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif
    localparam int FULL_LAT = 33;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall, busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    muldiv_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk(e.name, result, e.res);
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        exp_t e;
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk("stall_c0", 32'(stall), 32'd1);
        e.res = exp; e.cyc = cyc + lat; e.name = name;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk("stall", 32'(stall), 32'(k < lat));
            chk("busy", 32'(busy), 32'(k < lat));
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        issue(o, a, b, exp, lat, name);
        @(negedge clk);
    endtask

    initial begin
        int base;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT, "mul_7_m3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT, "mulhu_ff");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, FULL_LAT, "mulh_ff");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, FULL_LAT, "mulhsu_ff");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT, "rem_m7_2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, FULL_LAT, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, FULL_LAT, "remu_100_7");
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, EARLY_LAT, "div_5_0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, EARLY_LAT, "rem_5_0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, EARLY_LAT, "rem_ovf");
        run_op(3'd0, 32'd0, 32'd12345, 32'd0, EARLY_LAT, "mul_zero");

        // Flush at cycle 10 of a DIVU, then restart on cycle 11.
        start = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, FULL_LAT, "divu_after_flush");

        // Reset at cycle 5 of a MUL.
        start = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst5_stall", 32'(stall), 32'd0);
        chk("rst5_busy", 32'(busy), 32'd0);
        chk("rst5_done", 32'(done), 32'd0);
        chk("rst5_result", result, 32'd0);
        repeat (3) @(negedge clk);

        // Start held high through BUSY: one operation, one done pulse.
        base = done_seen;
        begin
            exp_t e;
            start = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd7;
            e.res = 32'd42; e.cyc = cyc + FULL_LAT; e.name = "mul_hold";
            sb.push_back(e);
        end
        for (int k = 1; k <= FULL_LAT; k++) begin
            @(negedge clk);
            if (k == FULL_LAT) start = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("hold_done_count", 32'(done_seen - base), 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 SHALL have start input 1: execute-stage request for an M-extension op, sampled only in IDLE.
REQ-003 SHALL have op input 3: funct3 encoding 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-004 SHALL have src_a input 32 (forwarded rs1 value) and src_b input 32 (forwarded rs2 value).
REQ-005 SHALL have flush input 1: branch/jump redirect; aborts any operation in progress.
REQ-006 SHALL have stall output 1: pipeline hold; execute-stage EN = ~stall.
REQ-007 SHALL have busy output 1 (iteration in progress), done output 1 (one-cycle result-valid pulse) and result output 32.

Function
REQ-008 SHALL implement states IDLE, BUSY and DONE.
REQ-009 SHALL, in IDLE with start=1 and flush=0, latch op, src_a and src_b, clear the iteration counter and go to BUSY.
REQ-010 SHALL drive stall combinationally as (IDLE & start & ~flush) | BUSY, and drive stall=0 in DONE.
REQ-011 SHALL perform one radix-2 step per BUSY cycle with a 6-bit counter, going to DONE after 32 steps.
REQ-012 SHALL, for an unmodified start at cycle 0, give BUSY on cycles 1..32 and done=1 on cycle 33.
REQ-013 SHALL hold result constant from the DONE cycle until the next accepted start, then return from DONE to IDLE unconditionally.
REQ-014 SHALL compute multiply as a 64-bit shift-add over sign-corrected magnitudes; MUL returns the low word, MULH/MULHSU/MULHU the high word.
REQ-015 SHALL compute divide as restoring division of magnitudes, then apply the signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-016 SHALL, on divide by zero, return quotient 0xFFFFFFFF and remainder src_a.
REQ-017 SHALL, on signed overflow (0x80000000 / 0xFFFFFFFF), return quotient 0x80000000 and remainder 0.
REQ-018 SHALL, on flush in any state, go to IDLE next cycle with no done pulse; flush has priority over start.
REQ-019 SHALL ignore start while in BUSY or DONE; no request is queued.
REQ-020 SHALL keep busy=1 exactly while in BUSY.

Reset
REQ-021 SHALL, on reset, set state IDLE, counter 0, stall 0, busy 0, done 0, result 0 and all operand/accumulator registers 0.
REQ-022 SHALL give reset priority over flush and start, and SHALL abort a BUSY operation on reset without a done pulse.

Configuration
REQ-023 SHALL, with MULDIV_EARLY_OUT_EN defined, go from IDLE directly to DONE (done on cycle 1, stall on cycle 0 only) in these cases: divide by zero, signed overflow, or either multiply operand 0.
REQ-024 SHALL, without MULDIV_EARLY_OUT_EN, take the full 32 iterations for every operand value, with the REQ-016/017 results still applied.

Structure
REQ-025 SHALL take the op encodings, the state enum, XLEN=32 and ITER_CNT=32 from shared package muldiv_pkg.
REQ-026 SHALL put the iterative shift/add/subtract datapath in one sub-module, muldiv_core; muldiv_sequencer holds the FSM, counter, sign handling and corner cases.

Verification
REQ-027 SHALL cover: MUL 7 x -3 -> done at cycle 33, result 0xFFFFFFEB, stall high on cycles 0..32.
REQ-028 SHALL cover: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> result 0x00000000.
REQ-029 SHALL cover: DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14.
REQ-030 SHALL cover: DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; done at cycle 1 with MULDIV_EARLY_OUT_EN, cycle 33 without.
REQ-031 SHALL cover: flush at cycle 10 of a DIVU -> IDLE on cycle 11, no done, stall 0; a new start on cycle 11 completes normally.
REQ-032 SHALL cover: reset at cycle 5 of a MUL -> all outputs 0 next cycle; start held high during BUSY -> exactly one done pulse.
